// File: rtl/evdb_multi_beat_if.sv
// Bundle of the evict data buffer's allocation, SRAM-write, drain-request and DS channels.
// The slave modport is the buffer side; the master modport is its surroundings.
interface evdb_multi_beat_if #(
  parameter int unsigned ENTRY_NUM    = 8,
  parameter int unsigned BEAT_NUM     = 4,
  parameter int unsigned DATA_WIDTH   = 1024,
  parameter int unsigned ROB_ID_WIDTH = 6,
  parameter int unsigned HDR_WIDTH    = 64,
  parameter int unsigned EID_W        = $clog2(ENTRY_NUM),
  parameter int unsigned BID_W        = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1
);
  logic                    alloc_vld;
  logic [EID_W-1:0]        alloc_idx;
  logic                    alloc_rdy;

  logic                    wr_vld;
  logic [EID_W-1:0]        wr_eid;
  logic [BID_W-1:0]        wr_bid;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_last;
  logic [ROB_ID_WIDTH-1:0] wr_rob_id;
  logic                    evict_clean;
  logic [ROB_ID_WIDTH-1:0] evict_clean_idx;
  logic                    wr_err;

  logic                    rd_req_vld;
  logic [EID_W-1:0]        rd_req_eid;
  logic [HDR_WIDTH-1:0]    rd_req_hdr;
  logic                    rd_req_rdy;

  logic                    ds_vld;
  logic [DATA_WIDTH-1:0]   ds_data;
  logic [BID_W-1:0]        ds_bid;
  logic                    ds_last;
  logic [HDR_WIDTH-1:0]    ds_hdr;
  logic [EID_W-1:0]        ds_eid;
  logic                    ds_rdy;

  logic [EID_W:0]          free_cnt;

  modport slave (
    output alloc_vld, alloc_idx,
    input  alloc_rdy,
    input  wr_vld, wr_eid, wr_bid, wr_data, wr_last, wr_rob_id,
    output evict_clean, evict_clean_idx, wr_err,
    input  rd_req_vld, rd_req_eid, rd_req_hdr,
    output rd_req_rdy,
    output ds_vld, ds_data, ds_bid, ds_last, ds_hdr, ds_eid,
    input  ds_rdy,
    output free_cnt
  );

  modport master (
    input  alloc_vld, alloc_idx,
    output alloc_rdy,
    output wr_vld, wr_eid, wr_bid, wr_data, wr_last, wr_rob_id,
    input  evict_clean, evict_clean_idx, wr_err,
    output rd_req_vld, rd_req_eid, rd_req_hdr,
    input  rd_req_rdy,
    input  ds_vld, ds_data, ds_bid, ds_last, ds_hdr, ds_eid,
    output ds_rdy,
    input  free_cnt
  );
endinterface

// File: rtl/evdb_multi_beat.sv
// Evict data buffer: pre-allocates victim-line entries, absorbs fixed-latency SRAM beats and
// drains each full line beat-by-beat to the downstream evict channel before recycling it.
module evdb_multi_beat #(
  parameter int unsigned ENTRY_NUM    = 8,
  parameter int unsigned BEAT_NUM     = 4,
  parameter int unsigned DATA_WIDTH   = 1024,
  parameter int unsigned ROB_ID_WIDTH = 6,
  parameter int unsigned HDR_WIDTH    = 64,
  parameter int unsigned EID_W        = $clog2(ENTRY_NUM),
  parameter int unsigned BID_W        = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1
) (
  input logic              clk,
  input logic              rst_n,
  evdb_multi_beat_if.slave bus
);
  localparam int unsigned Depth = ENTRY_NUM * BEAT_NUM;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = EID_W + 1;

  typedef enum logic [2:0] {EntIdle, EntAlloc, EntFill, EntFull, EntDrain} ent_st_e;
  typedef enum logic [0:0] {DIdle, DRun} drain_st_e;

  ent_st_e                 ent_q [ENTRY_NUM];
  ent_st_e                 ent_d [ENTRY_NUM];
  logic [CntW-1:0]         free_cnt_q, free_cnt_d;
  logic                    offer_hold_q, offer_hold_d;
  logic [EID_W-1:0]        offer_idx_q, offer_idx_d;
  logic                    evict_clean_q, evict_clean_d;
  logic [ROB_ID_WIDTH-1:0] evict_clean_idx_q, evict_clean_idx_d;
  logic                    wr_err_q, wr_err_d;

  drain_st_e               drain_q, drain_d;
  logic [BID_W-1:0]        cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    ds_vld_q, ds_vld_d;
  logic [DATA_WIDTH-1:0]   ds_data_q, ds_data_d;
  logic [BID_W-1:0]        ds_bid_q, ds_bid_d;
  logic                    ds_last_q, ds_last_d;
  logic [HDR_WIDTH-1:0]    ds_hdr_q, ds_hdr_d;
  logic [EID_W-1:0]        ds_eid_q, ds_eid_d;

  logic [DATA_WIDTH-1:0]   mem_q [Depth];

  logic [EID_W-1:0]        lowest_idle;
  logic                    alloc_vld;
  logic [EID_W-1:0]        alloc_idx;
  logic                    alloc_hs;
  logic                    wr_legal;
  logic [AddrW-1:0]        wr_addr;
  logic [AddrW-1:0]        rd_addr;
  logic                    rd_req_rdy;
  logic                    rd_hs;
  logic                    ds_hs;
  logic                    ds_last_hs;
  logic                    issue;
  logic                    cnt_is_last;

  // Lowest-index IDLE entry; the downward scan lets the smallest index win.
  always_comb begin
    lowest_idle = '0;
    for (int i = int'(ENTRY_NUM) - 1; i >= 0; i--) begin
      if (ent_q[i] == EntIdle) lowest_idle = EID_W'(i);
    end
  end

  // A pending offer is pinned so a lower entry released meanwhile cannot change it.
  assign alloc_vld   = (free_cnt_q != '0);
  assign alloc_idx   = offer_hold_q ? offer_idx_q : lowest_idle;
  assign alloc_hs    = alloc_vld & bus.alloc_rdy;

  assign wr_legal    = bus.wr_vld &
                       ((ent_q[bus.wr_eid] == EntAlloc) | (ent_q[bus.wr_eid] == EntFill));
  assign wr_addr     = AddrW'(32'(bus.wr_eid) * BEAT_NUM + 32'(bus.wr_bid));

  assign rd_req_rdy  = (drain_q == DIdle) & (ent_q[bus.rd_req_eid] == EntFull);
  assign rd_hs       = rd_req_rdy & bus.rd_req_vld;

  assign ds_hs       = ds_vld_q & bus.ds_rdy;
  assign ds_last_hs  = ds_hs & ds_last_q;
  // The array has one port; an SRAM write always wins it.
  assign issue       = (drain_q == DRun) & ~done_q & (~ds_vld_q | bus.ds_rdy) & ~bus.wr_vld;
  assign rd_addr     = AddrW'(32'(ds_eid_q) * BEAT_NUM + 32'(cnt_q));
  assign cnt_is_last = (cnt_q == BID_W'(BEAT_NUM - 1));

  always_comb begin
    for (int i = 0; i < int'(ENTRY_NUM); i++) ent_d[i] = ent_q[i];
    if (alloc_hs)   ent_d[alloc_idx]      = EntAlloc;
    if (wr_legal)   ent_d[bus.wr_eid]     = bus.wr_last ? EntFull : EntFill;
    if (rd_hs)      ent_d[bus.rd_req_eid] = EntDrain;
    if (ds_last_hs) ent_d[ds_eid_q]       = EntIdle;

    free_cnt_d        = free_cnt_q - CntW'(alloc_hs) + CntW'(ds_last_hs);
    offer_hold_d      = alloc_vld & ~bus.alloc_rdy;
    offer_idx_d       = alloc_idx;

    evict_clean_d     = wr_legal & bus.wr_last;
    evict_clean_idx_d = evict_clean_d ? bus.wr_rob_id : evict_clean_idx_q;
    wr_err_d          = bus.wr_vld & ~wr_legal;
  end

  always_comb begin
    drain_d   = drain_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    ds_vld_d  = ds_vld_q;
    ds_data_d = ds_data_q;
    ds_bid_d  = ds_bid_q;
    ds_last_d = ds_last_q;
    ds_hdr_d  = ds_hdr_q;
    ds_eid_d  = ds_eid_q;
    unique case (drain_q)
      DIdle: begin
        if (rd_hs) begin
          drain_d  = DRun;
          ds_hdr_d = bus.rd_req_hdr;
          ds_eid_d = bus.rd_req_eid;
          cnt_d    = '0;
          done_d   = 1'b0;
        end
      end
      DRun: begin
        if (issue) begin
          ds_vld_d  = 1'b1;
          ds_data_d = mem_q[rd_addr];
          ds_bid_d  = cnt_q;
          ds_last_d = cnt_is_last;
          cnt_d     = cnt_q + 1'b1;
          done_d    = cnt_is_last;
        end else if (ds_hs) begin
          ds_vld_d  = 1'b0;
        end
        if (ds_last_hs) drain_d = DIdle;
      end
      default: drain_d = DIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRY_NUM); i++) ent_q[i] <= EntIdle;
      free_cnt_q        <= CntW'(ENTRY_NUM);
      offer_hold_q      <= 1'b0;
      offer_idx_q       <= '0;
      evict_clean_q     <= 1'b0;
      evict_clean_idx_q <= '0;
      wr_err_q          <= 1'b0;
      drain_q           <= DIdle;
      cnt_q             <= '0;
      done_q            <= 1'b0;
      ds_vld_q          <= 1'b0;
      ds_data_q         <= '0;
      ds_bid_q          <= '0;
      ds_last_q         <= 1'b0;
      ds_hdr_q          <= '0;
      ds_eid_q          <= '0;
    end else begin
      for (int i = 0; i < int'(ENTRY_NUM); i++) ent_q[i] <= ent_d[i];
      free_cnt_q        <= free_cnt_d;
      offer_hold_q      <= offer_hold_d;
      offer_idx_q       <= offer_idx_d;
      evict_clean_q     <= evict_clean_d;
      evict_clean_idx_q <= evict_clean_idx_d;
      wr_err_q          <= wr_err_d;
      drain_q           <= drain_d;
      cnt_q             <= cnt_d;
      done_q            <= done_d;
      ds_vld_q          <= ds_vld_d;
      ds_data_q         <= ds_data_d;
      ds_bid_q          <= ds_bid_d;
      ds_last_q         <= ds_last_d;
      ds_hdr_q          <= ds_hdr_d;
      ds_eid_q          <= ds_eid_d;
    end
  end

  // Line storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_legal) mem_q[wr_addr] <= bus.wr_data;
  end

  assign bus.alloc_vld       = alloc_vld;
  assign bus.alloc_idx       = alloc_idx;
  assign bus.evict_clean     = evict_clean_q;
  assign bus.evict_clean_idx = evict_clean_idx_q;
  assign bus.wr_err          = wr_err_q;
  assign bus.rd_req_rdy      = rd_req_rdy;
  assign bus.ds_vld          = ds_vld_q;
  assign bus.ds_data         = ds_data_q;
  assign bus.ds_bid          = ds_bid_q;
  assign bus.ds_last         = ds_last_q;
  assign bus.ds_hdr          = ds_hdr_q;
  assign bus.ds_eid          = ds_eid_q;
  assign bus.free_cnt        = free_cnt_q;
endmodule
